pipe_stage_ctrl: RTL and testbench
==================================

# pipe_stage_ctrl

Pipeline register bank and stage sequencer for the 5-stage pipelined core; it consumes the stall/flush outputs of the hazard unit and applies them. It owns the PC register and the IF/DEC, DEC/EX, EX/MEM and MEM/WB instruction registers. It inserts bubbles, holds stages, and redirects the PC, and it counts stalls, flushes and retired instructions for debug.

## Interface
- RESET_VEC, 32'h0000_0000, PC value loaded on reset
- CLK  in  1  core clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- pc_next  in  32  next sequential/branch-target PC from PC mux
- if_ir  in  32  instruction word fetched at current `pc`
- dec_instr  in  instr_t  decoded instruction from decoder (DEC stage)
- ex_instr_out  in  instr_t  EX-stage instruction with control resolved
- mem_instr_out  in  instr_t  MEM-stage instruction
- LW_STALL  in  1  load-use stall request
- IF_FLUSH  in  1  discard instruction entering DEC
- DEC_FLUSH  in  1  control-transfer redirect; discard IF/DEC and DEC/EX contents
- EX_FLUSH  in  1  inject bubble into DEC/EX
- MEM_BUSY  in  1  data memory not ready; freeze entire pipeline
- pc  out  32  current fetch PC
- if_dec_ir, if_dec_pc  out  32 each  IF/DEC register contents
- if_dec_valid  out  1  IF/DEC holds a real instruction
- dec_ex, ex_mem, mem_wb  out  instr_t each  stage registers
- stall_cnt, flush_cnt, instret_cnt  out  32 each  event counters

## Operation
- Bubble = instr_t all zeros (opcode FLUSH, regWrite/memWrite/memRead2/rd_used = 0, ir = 0, pc = 0). IF/DEC bubble = ir 0, pc 0, valid 0.
- Priority per edge, highest first: RST > MEM_BUSY > DEC_FLUSH > LW_STALL > IF_FLUSH/EX_FLUSH > normal advance.
- RST: pc = RESET_VEC; all stage registers bubble; all counters 0.
- MEM_BUSY=1: every register and counter holds. All other requests are ignored that cycle; the hazard unit re-presents them.
- DEC_FLUSH=1 (not busy): pc <= pc_next; IF/DEC <= bubble; DEC/EX <= bubble; EX/MEM <= ex_instr_out; MEM/WB <= mem_instr_out. LW_STALL in the same cycle is overridden because the stalled instruction is on the wrong path.
- LW_STALL=1 (no DEC_FLUSH): pc holds; IF/DEC holds; DEC/EX <= bubble; EX/MEM and MEM/WB advance.
- IF_FLUSH=1: IF/DEC <= bubble; pc <= pc_next unless LW_STALL holds it.
- EX_FLUSH=1: DEC/EX <= bubble. Same effect as the LW_STALL bubble; it does not hold pc.
- Normal: pc <= pc_next; IF/DEC <= {if_ir, pc, 1}; DEC/EX <= dec_instr; EX/MEM <= ex_instr_out; MEM/WB <= mem_instr_out.
- Counters (only when not RST and not MEM_BUSY), each 32-bit and wrapping 0xFFFF_FFFF -> 0:
  - stall_cnt +1 on any cycle with effective LW_STALL.
  - flush_cnt +1 on any cycle with DEC_FLUSH, IF_FLUSH or EX_FLUSH effective; +1 at most per cycle.
  - instret_cnt +1 when the current mem_wb.opcode != FLUSH. This counts the retiring instruction leaving WB.

## Timing
- All outputs are registered and change only on a rising CLK edge. There are no combinational paths from inputs to outputs.
- Fetch-to-WB latency is 4 edges with no stalls: an instruction latched into IF/DEC at edge n appears in mem_wb at edge n+3 and is counted at edge n+4.
- Each LW_STALL cycle adds exactly one bubble and one cycle of latency. The held instruction re-enters DEC/EX on the first non-stall edge.
- RST asserted mid-operation takes effect at the next edge regardless of MEM_BUSY. The first fetch after reset release uses pc = RESET_VEC.
- Stall/flush inputs are sampled only at edges. Multi-cycle assertion repeats the action every edge.

## Test plan
- Reset: RST high 2 cycles with RESET_VEC=32'h100 -> pc=0x100, dec_ex/ex_mem/mem_wb opcode FLUSH, if_dec_valid=0, all counters 0.
- Straight-line: 6 OP instructions, pc_next=pc+4, no hazards -> first instruction in mem_wb 3 edges after latching IF/DEC; instret_cnt=6 after 10 edges; stall_cnt=flush_cnt=0.
- Load-use: LW_STALL for 1 cycle with IF/DEC=0x00208133 -> pc and IF/DEC unchanged, dec_ex = bubble, next edge dec_ex.ir=0x00208133; stall_cnt=1.
- Branch redirect with stall: DEC_FLUSH and LW_STALL together, pc_next=0x200 -> pc=0x200, IF/DEC and DEC/EX bubbles, stall_cnt unchanged, flush_cnt=1.
- Memory freeze: MEM_BUSY high 3 cycles while LW_STALL=1 and DEC_FLUSH=1 -> all outputs and counters constant for 3 edges; on release the requests act normally.
- Counter wrap: instret_cnt forced to 0xFFFF_FFFF, one retiring instruction -> instret_cnt=0; RST mid-stream -> all counters 0 next edge.

Source files
------------

// File: rtl/pipe_stage_ctrl_if.sv
// rtl/pipe_stage_ctrl_if.sv - instruction record type and pipeline control bus
//
// pipe_stage_pkg
//   opcode_t : instruction class; FLUSH (all zeros) marks a bubble
//   instr_t  : stage register record {opcode, reg_write, mem_write,
//              mem_read2, rd_used, ir, pc}; all zeros is a bubble
//
// pipe_stage_ctrl_if
//   inputs to the sequencer : pc_next, if_ir, dec_instr, ex_instr_out,
//                             mem_instr_out, LW_STALL, IF_FLUSH, DEC_FLUSH,
//                             EX_FLUSH, MEM_BUSY
//   outputs of the sequencer: pc, if_dec_ir, if_dec_pc, if_dec_valid,
//                             dec_ex, ex_mem, mem_wb, stall_cnt, flush_cnt,
//                             instret_cnt
//   modport master : core/hazard side, drives the inputs
//   modport slave  : pipe_stage_ctrl

package pipe_stage_pkg;

    typedef enum logic [3:0] {
        FLUSH  = 4'd0,
        OP     = 4'd1,
        OP_IMM = 4'd2,
        LOAD   = 4'd3,
        STORE  = 4'd4,
        BRANCH = 4'd5,
        JAL    = 4'd6,
        JALR   = 4'd7,
        LUI    = 4'd8,
        AUIPC  = 4'd9,
        SYSTEM = 4'd10
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read2;
        logic        rd_used;
        logic [31:0] ir;
        logic [31:0] pc;
    } instr_t;

    localparam instr_t BUBBLE = '0;

endpackage

interface pipe_stage_ctrl_if;
    import pipe_stage_pkg::*;

    logic [31:0] pc_next;
    logic [31:0] if_ir;
    instr_t      dec_instr;
    instr_t      ex_instr_out;
    instr_t      mem_instr_out;
    logic        LW_STALL;
    logic        IF_FLUSH;
    logic        DEC_FLUSH;
    logic        EX_FLUSH;
    logic        MEM_BUSY;

    logic [31:0] pc;
    logic [31:0] if_dec_ir;
    logic [31:0] if_dec_pc;
    logic        if_dec_valid;
    instr_t      dec_ex;
    instr_t      ex_mem;
    instr_t      mem_wb;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] instret_cnt;

    modport master (
        output pc_next, if_ir, dec_instr, ex_instr_out, mem_instr_out,
               LW_STALL, IF_FLUSH, DEC_FLUSH, EX_FLUSH, MEM_BUSY,
        input  pc, if_dec_ir, if_dec_pc, if_dec_valid, dec_ex, ex_mem, mem_wb,
               stall_cnt, flush_cnt, instret_cnt
    );

    modport slave (
        input  pc_next, if_ir, dec_instr, ex_instr_out, mem_instr_out,
               LW_STALL, IF_FLUSH, DEC_FLUSH, EX_FLUSH, MEM_BUSY,
        output pc, if_dec_ir, if_dec_pc, if_dec_valid, dec_ex, ex_mem, mem_wb,
               stall_cnt, flush_cnt, instret_cnt
    );

endinterface

// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - pipeline register bank, stall/flush sequencer and debug counters
//
// Parameters
//   RESET_VEC : PC loaded on reset
// Ports
//   CLK : core clock, all state changes on the rising edge
//   RST : synchronous active-high reset
//   bus : pipe_stage_ctrl_if.slave (PC mux / fetch / decode / hazard inputs,
//         PC, stage registers and event counters out; all outputs registered)

module pipe_stage_ctrl
    import pipe_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RST,
    pipe_stage_ctrl_if.slave   bus
);

    logic [31:0] pc_q;
    logic [31:0] if_dec_ir_q;
    logic [31:0] if_dec_pc_q;
    logic        if_dec_valid_q;
    instr_t      dec_ex_q;
    instr_t      ex_mem_q;
    instr_t      mem_wb_q;
    logic [31:0] stall_q;
    logic [31:0] flush_q;
    logic [31:0] instret_q;

    // Effective requests after priority resolution. MEM_BUSY masks
    // everything; DEC_FLUSH cancels a simultaneous load-use stall because
    // the stalled instruction is on the squashed path.
    logic take_dec_flush;
    logic take_stall;
    logic take_if_flush;
    logic take_ex_flush;
    logic take_any_flush;
    logic bubble_dec_ex;
    logic retiring;

    always_comb begin
        take_dec_flush = 1'b0;
        take_stall     = 1'b0;
        take_if_flush  = 1'b0;
        take_ex_flush  = 1'b0;
        if (!bus.MEM_BUSY) begin
            take_dec_flush = bus.DEC_FLUSH;
            take_stall     = bus.LW_STALL && !bus.DEC_FLUSH;
            take_if_flush  = bus.IF_FLUSH;
            take_ex_flush  = bus.EX_FLUSH;
        end
        take_any_flush = take_dec_flush || take_if_flush || take_ex_flush;
        bubble_dec_ex  = take_dec_flush || take_stall || take_ex_flush;
        // The instruction sitting in MEM/WB completes as this edge moves it out.
        retiring       = (mem_wb_q.opcode != FLUSH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q           <= RESET_VEC;
            if_dec_ir_q    <= '0;
            if_dec_pc_q    <= '0;
            if_dec_valid_q <= 1'b0;
            dec_ex_q       <= BUBBLE;
            ex_mem_q       <= BUBBLE;
            mem_wb_q       <= BUBBLE;
            stall_q        <= '0;
            flush_q        <= '0;
            instret_q      <= '0;
        end else if (!bus.MEM_BUSY) begin
            // A load-use stall holds fetch so the same instruction is re-presented.
            if (!take_stall) begin
                pc_q <= bus.pc_next;
            end

            if (take_dec_flush || take_if_flush) begin
                if_dec_ir_q    <= '0;
                if_dec_pc_q    <= '0;
                if_dec_valid_q <= 1'b0;
            end else if (!take_stall) begin
                if_dec_ir_q    <= bus.if_ir;
                if_dec_pc_q    <= pc_q;
                if_dec_valid_q <= 1'b1;
            end

            dec_ex_q <= bubble_dec_ex ? BUBBLE : bus.dec_instr;
            ex_mem_q <= bus.ex_instr_out;
            mem_wb_q <= bus.mem_instr_out;

            if (take_stall) begin
                stall_q <= stall_q + 32'd1;
            end
            if (take_any_flush) begin
                flush_q <= flush_q + 32'd1;
            end
            if (retiring) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign bus.pc           = pc_q;
    assign bus.if_dec_ir    = if_dec_ir_q;
    assign bus.if_dec_pc    = if_dec_pc_q;
    assign bus.if_dec_valid = if_dec_valid_q;
    assign bus.dec_ex       = dec_ex_q;
    assign bus.ex_mem       = ex_mem_q;
    assign bus.mem_wb       = mem_wb_q;
    assign bus.stall_cnt    = stall_q;
    assign bus.flush_cnt    = flush_q;
    assign bus.instret_cnt  = instret_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb/tb_pipe_stage_ctrl.sv - self-checking bench for pipe_stage_ctrl

module tb_pipe_stage_ctrl;
    import pipe_stage_pkg::*;

    localparam logic [31:0] RV  = 32'h0000_0100;
    localparam logic [4:0]  NRM = 5'b00000;
    localparam logic [4:0]  LW  = 5'b10000;
    localparam logic [4:0]  DF  = 5'b01000;
    localparam logic [4:0]  IFL = 5'b00100;
    localparam logic [4:0]  EXF = 5'b00010;
    localparam logic [4:0]  BSY = 5'b00001;

    typedef struct {
        logic [4:0]  ctl;      // {lw, dec_flush, if_flush, ex_flush, busy}
        logic [31:0] pn;
        logic [31:0] ir;
        logic [31:0] e_pc;
        logic        e_v;
        logic [31:0] e_ifir;
        logic [31:0] e_ifpc;
        logic [31:0] e_dex;
        logic [31:0] e_exm;
        logic [31:0] e_mwb;
        logic [31:0] e_st;
        logic [31:0] e_fl;
        logic [31:0] e_in;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    int   n_cmp = 0;
    int   n_bad = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    pipe_stage_ctrl_if bus ();

    pipe_stage_ctrl #(.RESET_VEC(RV)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Simple decoder / pipeline loopback: a valid non-zero IF/DEC word
    // decodes to an OP instruction, everything else to a bubble.
    always_comb begin
        bus.dec_instr = '0;
        if (bus.if_dec_valid && bus.if_dec_ir != 32'd0) begin
            bus.dec_instr.opcode    = OP;
            bus.dec_instr.reg_write = 1'b1;
            bus.dec_instr.rd_used   = 1'b1;
            bus.dec_instr.ir        = bus.if_dec_ir;
            bus.dec_instr.pc        = bus.if_dec_pc;
        end
        bus.ex_instr_out  = bus.dec_ex;
        bus.mem_instr_out = bus.ex_mem;
    end

    function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] pn, ir, p,
                                input logic v, input logic [31:0] ifir, ifpc, dex,
                                exm, mwb, st, fl, in);
        vec_t r;
        r.ctl = ctl; r.pn = pn; r.ir = ir; r.e_pc = p; r.e_v = v;
        r.e_ifir = ifir; r.e_ifpc = ifpc; r.e_dex = dex; r.e_exm = exm;
        r.e_mwb = mwb; r.e_st = st; r.e_fl = fl; r.e_in = in;
        return r;
    endfunction

    function automatic logic [31:0] sl(input int k);
        return 32'h0000_0033 | (32'(k + 1) << 20);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ctl, input logic [31:0] pn, input logic [31:0] ir);
        bus.LW_STALL  = ctl[4];
        bus.DEC_FLUSH = ctl[3];
        bus.IF_FLUSH  = ctl[2];
        bus.EX_FLUSH  = ctl[1];
        bus.MEM_BUSY  = ctl[0];
        bus.pc_next   = pn;
        bus.if_ir     = ir;
    endtask

    task automatic check_vec(input vec_t v, input int i);
        chk($sformatf("v%0d pc", i),         bus.pc,                 v.e_pc);
        chk($sformatf("v%0d if_dec_valid", i), 32'(bus.if_dec_valid), 32'(v.e_v));
        chk($sformatf("v%0d if_dec_ir", i),  bus.if_dec_ir,          v.e_ifir);
        chk($sformatf("v%0d if_dec_pc", i),  bus.if_dec_pc,          v.e_ifpc);
        chk($sformatf("v%0d dec_ex.ir", i),  bus.dec_ex.ir,          v.e_dex);
        chk($sformatf("v%0d ex_mem.ir", i),  bus.ex_mem.ir,          v.e_exm);
        chk($sformatf("v%0d mem_wb.ir", i),  bus.mem_wb.ir,          v.e_mwb);
        chk($sformatf("v%0d stall_cnt", i),  bus.stall_cnt,          v.e_st);
        chk($sformatf("v%0d flush_cnt", i),  bus.flush_cnt,          v.e_fl);
        chk($sformatf("v%0d instret_cnt", i), bus.instret_cnt,       v.e_in);
    endtask

    initial begin
        // Straight-line: six OP instructions then zero words, pc_next = pc + 4.
        for (int e = 1; e <= 10; e++) begin
            vecs.push_back(mk(NRM, RV + 32'(4 * e), (e <= 6) ? sl(e - 1) : 32'd0,
                RV + 32'(4 * e), 1'b1,
                (e <= 6) ? sl(e - 1) : 32'd0,
                RV + 32'(4 * (e - 1)),
                (e >= 2 && e <= 7) ? sl(e - 2) : 32'd0,
                (e >= 3 && e <= 8) ? sl(e - 3) : 32'd0,
                (e >= 4 && e <= 9) ? sl(e - 4) : 32'd0,
                32'd0, 32'd0,
                (e <= 4) ? 32'd0 : 32'(e - 4)));
        end
        // Load-use stall on 0x00208133
        vecs.push_back(mk(NRM, 32'h12c, 32'h0020_8133, 32'h12c, 1, 32'h0020_8133, 32'h128, 0, 0, 0, 0, 0, 6));
        vecs.push_back(mk(LW,  32'h130, 32'hdead_0013, 32'h12c, 1, 32'h0020_8133, 32'h128, 0, 0, 0, 1, 0, 6));
        vecs.push_back(mk(NRM, 32'h130, 32'h0,         32'h130, 1, 0, 32'h12c, 32'h0020_8133, 0, 0, 1, 0, 6));
        vecs.push_back(mk(NRM, 32'h134, 32'h0,         32'h134, 1, 0, 32'h130, 0, 32'h0020_8133, 0, 1, 0, 6));
        vecs.push_back(mk(NRM, 32'h138, 32'h0,         32'h138, 1, 0, 32'h134, 0, 0, 32'h0020_8133, 1, 0, 6));
        vecs.push_back(mk(NRM, 32'h13c, 32'h0050_0093, 32'h13c, 1, 32'h0050_0093, 32'h138, 0, 0, 0, 1, 0, 7));
        // Branch redirect together with load-use stall
        vecs.push_back(mk(LW|DF, 32'h200, 32'h1111_1111, 32'h200, 0, 0, 0, 0, 0, 0, 1, 1, 7));
        vecs.push_back(mk(NRM, 32'h204, 32'h00a0_0113, 32'h204, 1, 32'h00a0_0113, 32'h200, 0, 0, 0, 1, 1, 7));
        vecs.push_back(mk(NRM, 32'h208, 32'h0,         32'h208, 1, 0, 32'h204, 32'h00a0_0113, 0, 0, 1, 1, 7));
        // Memory freeze for 3 edges with stall and redirect pending
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(LW|DF|BSY, 32'h300, 32'h2222_2222, 32'h208, 1, 0, 32'h204, 32'h00a0_0113, 0, 0, 1, 1, 7));
        end
        vecs.push_back(mk(LW|DF, 32'h300, 32'h3333_3333, 32'h300, 0, 0, 0, 0, 32'h00a0_0113, 0, 1, 2, 7));
        vecs.push_back(mk(NRM, 32'h304, 32'h0,         32'h304, 1, 0, 32'h300, 0, 0, 32'h00a0_0113, 1, 2, 7));
        vecs.push_back(mk(NRM, 32'h308, 32'h0,         32'h308, 1, 0, 32'h304, 0, 0, 0, 1, 2, 8));
        // IF_FLUSH and EX_FLUSH
        vecs.push_back(mk(IFL, 32'h30c, 32'h00c0_0193, 32'h30c, 0, 0, 0, 0, 0, 0, 1, 3, 8));
        vecs.push_back(mk(NRM, 32'h310, 32'h00d0_0213, 32'h310, 1, 32'h00d0_0213, 32'h30c, 0, 0, 0, 1, 3, 8));
        vecs.push_back(mk(EXF, 32'h314, 32'h0,         32'h314, 1, 0, 32'h310, 0, 0, 0, 1, 4, 8));
        vecs.push_back(mk(NRM, 32'h318, 32'h0,         32'h318, 1, 0, 32'h314, 0, 0, 0, 1, 4, 8));
        // Carry one instruction down to MEM/WB for the wrap check
        vecs.push_back(mk(NRM, 32'h31c, 32'h00e0_0293, 32'h31c, 1, 32'h00e0_0293, 32'h318, 0, 0, 0, 1, 4, 8));
        vecs.push_back(mk(NRM, 32'h320, 32'h0,         32'h320, 1, 0, 32'h31c, 32'h00e0_0293, 0, 0, 1, 4, 8));
        vecs.push_back(mk(NRM, 32'h324, 32'h0,         32'h324, 1, 0, 32'h320, 0, 32'h00e0_0293, 0, 1, 4, 8));
        vecs.push_back(mk(NRM, 32'h328, 32'h0,         32'h328, 1, 0, 32'h324, 0, 0, 32'h00e0_0293, 1, 4, 8));

        // Reset: two edges
        RST = 1'b1;
        drive(NRM, 32'h0, 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst pc",           bus.pc,                   RV);
        chk("rst if_dec_valid", 32'(bus.if_dec_valid),    32'd0);
        chk("rst dec_ex op",    32'(bus.dec_ex.opcode),   32'(FLUSH));
        chk("rst ex_mem op",    32'(bus.ex_mem.opcode),   32'(FLUSH));
        chk("rst mem_wb op",    32'(bus.mem_wb.opcode),   32'(FLUSH));
        chk("rst stall_cnt",    bus.stall_cnt,            32'd0);
        chk("rst flush_cnt",    bus.flush_cnt,            32'd0);
        chk("rst instret_cnt",  bus.instret_cnt,          32'd0);
        RST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            drive(vecs[i].ctl, vecs[i].pn, vecs[i].ir);
            exp_q.push_back(vecs[i]);
            @(posedge CLK);
            @(negedge CLK);
            v = exp_q.pop_front();
            check_vec(v, i);
        end

        // Counter wrap: MEM/WB holds a real instruction, counter at all-ones
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        chk("wrap preset", bus.instret_cnt, 32'hFFFF_FFFF);
        drive(NRM, 32'h32c, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        chk("wrap instret_cnt", bus.instret_cnt, 32'd0);
        chk("wrap pc",          bus.pc,          32'h32c);
        chk("wrap stall_cnt",   bus.stall_cnt,   32'd1);

        // Reset mid-stream wins over MEM_BUSY
        RST = 1'b1;
        drive(LW|BSY, 32'h400, 32'h4444_4444);
        @(posedge CLK);
        @(negedge CLK);
        chk("midrst pc",           bus.pc,                 RV);
        chk("midrst if_dec_valid", 32'(bus.if_dec_valid),  32'd0);
        chk("midrst mem_wb op",    32'(bus.mem_wb.opcode), 32'(FLUSH));
        chk("midrst stall_cnt",    bus.stall_cnt,          32'd0);
        chk("midrst flush_cnt",    bus.flush_cnt,          32'd0);
        chk("midrst instret_cnt",  bus.instret_cnt,        32'd0);
        RST = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
